// File: rtl/psram_fetch_pkg.sv
// Shared types and constants for the PSRAM frame fetcher.
`timescale 1ns/1ps
package psram_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_DATA,
    ST_DRAIN
  } fetch_state_t;

  localparam logic PSRAM_CMD_READ = 1'b0;
  localparam int   FIFO_W         = 34;

  // One FIFO entry: stream tags plus the PSRAM word.
  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [31:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/psram_frame_fetch_if.sv
// PSRAM read-command bus plus the outgoing pixel stream.
// master = fetcher side, slave = PSRAM controller / stream consumer side.
`timescale 1ns/1ps
interface psram_frame_fetch_if;
  logic        psram_cmd;
  logic        psram_cmd_en;
  logic [20:0] psram_addr;
  logic        psram_cmd_ready;
  logic [31:0] psram_rdata;
  logic        psram_rvalid;
  logic [31:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_valid;
  logic        pix_ready;

  modport master (
    output psram_cmd, psram_cmd_en, psram_addr,
    input  psram_cmd_ready, psram_rdata, psram_rvalid,
    output pix_data, pix_sof, pix_eol, pix_valid,
    input  pix_ready
  );

  modport slave (
    input  psram_cmd, psram_cmd_en, psram_addr,
    output psram_cmd_ready, psram_rdata, psram_rvalid,
    input  pix_data, pix_sof, pix_eol, pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Single-clock show-ahead FIFO: dout is the head entry whenever count != 0.
`timescale 1ns/1ps
module fetch_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push_ok, pop_ok;

  assign empty   = (count == '0);
  assign push_ok = push && (count != CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rptr];

  // Storage array; contents need no reset since empty gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

  // Pointer and occupancy tracking; simultaneous push/pop holds count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/psram_frame_fetch.sv
// PSRAM frame fetcher: walks an H_WORDS x V_LINES frame in fixed bursts with
// a programmable line stride, buffers words in a show-ahead FIFO and emits
// them on a valid/ready stream tagged with sof/eol.
// Optional: FETCH_DBUF_EN selects base_adrs0/base_adrs1 per frame via buf_sel.
`timescale 1ns/1ps
module psram_frame_fetch
  import psram_fetch_pkg::*;
#(
  parameter int H_WORDS     = 1280,
  parameter int V_LINES     = 720,
  parameter int BURST_WORDS = 16,
  parameter int FIFO_DEPTH  = 64
) (
  input  logic                   psramclk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [20:0]            base_adrs0,
  input  logic [20:0]            base_adrs1,
  input  logic                   buf_sel,
  input  logic [20:0]            line_stride,
  psram_frame_fetch_if.master    bus,
  output logic                   run,
  output logic                   cur_buf,
  output logic                   frame_done,
  output logic                   spurious_rvalid
);
  localparam int WOW = $clog2(H_WORDS + 1);
  localparam int LW  = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int BTW = $clog2(BURST_WORDS);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  fetch_state_t   state;
  logic [20:0]    line_base;
  logic [WOW-1:0] word_off;
  logic [LW-1:0]  line;
  logic [BTW-1:0] beat;
  logic           stop_pend;

  logic [20:0]    nxt_base;
  logic           nxt_buf;
  fifo_entry_t    push_e, pop_e;
  logic           fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0]  fifo_cnt;
  logic           last_beat, line_end, frame_end, room;

`ifdef FETCH_DBUF_EN
  assign nxt_base = buf_sel ? base_adrs1 : base_adrs0;
  assign nxt_buf  = buf_sel;
`else
  logic unused_dbuf;
  assign unused_dbuf = ^{base_adrs1, buf_sel};
  assign nxt_base    = base_adrs0;
  assign nxt_buf     = 1'b0;
`endif

  assign run       = (state != ST_IDLE);
  assign last_beat = (beat == BTW'(BURST_WORDS - 1));
  assign line_end  = (int'(word_off) + BURST_WORDS == H_WORDS);
  assign frame_end = (int'(line) == V_LINES - 1);
  // Only one burst is ever in flight, so this check alone prevents overflow.
  assign room      = (int'(fifo_cnt) <= FIFO_DEPTH - BURST_WORDS);

  // Tag each incoming beat with its frame/line position.
  always_comb begin
    push_e      = '0;
    push_e.data = bus.psram_rdata;
    push_e.sof  = (line == '0) && (word_off == '0) && (beat == '0);
    push_e.eol  = (int'(word_off) + int'(beat) == H_WORDS - 1);
  end

  assign fifo_push = (state == ST_DATA) && bus.psram_rvalid;
  assign fifo_pop  = bus.pix_valid && bus.pix_ready;

  fetch_fifo #(.W(FIFO_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (psramclk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (push_e),
    .pop   (fifo_pop),
    .dout  (pop_e),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Stream outputs are forced to 0 while empty so stale RAM never leaks out.
  assign bus.pix_valid = !fifo_empty;
  assign bus.pix_data  = fifo_empty ? 32'h0 : pop_e.data;
  assign bus.pix_sof   = !fifo_empty && pop_e.sof;
  assign bus.pix_eol   = !fifo_empty && pop_e.eol;
  assign bus.psram_cmd = PSRAM_CMD_READ;

  // Fetch sequencer: frame walk, burst requests, stop handling, error flag.
  always_ff @(posedge psramclk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      line_base        <= '0;
      word_off         <= '0;
      line             <= '0;
      beat             <= '0;
      stop_pend        <= 1'b0;
      cur_buf          <= 1'b0;
      frame_done       <= 1'b0;
      spurious_rvalid  <= 1'b0;
      bus.psram_cmd_en <= 1'b0;
      bus.psram_addr   <= '0;
    end else begin
      frame_done <= 1'b0;
      if (run && stop) stop_pend <= 1'b1;
      if (bus.psram_rvalid && state != ST_DATA) spurious_rvalid <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state     <= ST_CHECK;
            line_base <= nxt_base;
            cur_buf   <= nxt_buf;
            word_off  <= '0;
            line      <= '0;
          end
        end
        ST_CHECK: begin
          if (stop_pend || stop) begin
            state <= ST_DRAIN;
          end else if (room) begin
            state            <= ST_REQ;
            bus.psram_cmd_en <= 1'b1;
            bus.psram_addr   <= line_base + 21'(word_off);
          end
        end
        ST_REQ: begin
          if (bus.psram_cmd_ready) begin
            state            <= ST_DATA;
            bus.psram_cmd_en <= 1'b0;
            beat             <= '0;
          end
        end
        ST_DATA: begin
          if (bus.psram_rvalid) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              state <= ST_CHECK;
              if (line_end) begin
                word_off <= '0;
                if (frame_end) begin
                  frame_done <= 1'b1;
                  line       <= '0;
                  line_base  <= nxt_base;
                  cur_buf    <= nxt_buf;
                end else begin
                  line      <= line + 1'b1;
                  line_base <= line_base + line_stride;
                end
              end else begin
                word_off <= word_off + WOW'(BURST_WORDS);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state     <= ST_IDLE;
            stop_pend <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psram_frame_fetch.sv
// Directed bench for psram_frame_fetch (32x2 frame, 16-word bursts, 32-deep FIFO).
`timescale 1ns/1ps
module tb_psram_frame_fetch;
  localparam int H = 32;
  localparam int V = 2;
  localparam int B = 16;
  localparam int FD = 32;

  logic        psramclk, rst_n, start, stop, buf_sel;
  logic [20:0] base0, base1, stride;
  logic        run, cur_buf, frame_done, spurious;
  logic        cmd_rdy, pix_rdy, force_rv;

  psram_frame_fetch_if bus();

  psram_frame_fetch #(.H_WORDS(H), .V_LINES(V), .BURST_WORDS(B), .FIFO_DEPTH(FD)) dut (
    .psramclk        (psramclk),
    .rst_n           (rst_n),
    .start           (start),
    .stop            (stop),
    .base_adrs0      (base0),
    .base_adrs1      (base1),
    .buf_sel         (buf_sel),
    .line_stride     (stride),
    .bus             (bus),
    .run             (run),
    .cur_buf         (cur_buf),
    .frame_done      (frame_done),
    .spurious_rvalid (spurious)
  );

  initial psramclk = 1'b0;
  always #5 psramclk = ~psramclk;

  function automatic logic [31:0] tag(input logic [20:0] a);
    return 32'hA500_0000 | {11'h0, a};
  endfunction

  // PSRAM model: accepts a command, waits 2 cycles, returns B sequential words.
  logic [20:0] cmd_q[$];
  logic [33:0] pop_q[$];
  int          fd_at;
  logic        m_rv;
  logic [31:0] m_rd;
  logic [20:0] rq_addr;
  int          rq_cnt, rq_dly;

  assign bus.psram_cmd_ready = cmd_rdy;
  assign bus.pix_ready       = pix_rdy;
  assign bus.psram_rvalid    = m_rv | force_rv;
  assign bus.psram_rdata     = force_rv ? 32'hDEAD_BEEF : m_rd;

  always @(posedge psramclk or negedge rst_n) begin
    if (!rst_n) begin
      m_rv   <= 1'b0;
      m_rd   <= '0;
      rq_cnt <= 0;
      rq_dly <= 0;
    end else begin
      m_rv <= 1'b0;
      if (bus.psram_cmd_en && bus.psram_cmd_ready) begin
        cmd_q.push_back(bus.psram_addr);
        rq_addr <= bus.psram_addr;
        rq_cnt  <= B;
        rq_dly  <= 2;
      end else if (rq_cnt > 0) begin
        if (rq_dly > 0) rq_dly <= rq_dly - 1;
        else begin
          m_rv    <= 1'b1;
          m_rd    <= tag(rq_addr);
          rq_addr <= rq_addr + 21'd1;
          rq_cnt  <= rq_cnt - 1;
        end
      end
    end
  end

  // Stream and frame_done logger.
  always @(posedge psramclk) begin
    if (rst_n && bus.pix_valid && bus.pix_ready)
      pop_q.push_back({bus.pix_sof, bus.pix_eol, bus.pix_data});
    if (rst_n && frame_done && fd_at < 0) fd_at = cmd_q.size();
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tg, obs, exp);
    end
  endtask

  // Compare the first 64 popped words against one frame from base/stride.
  task automatic chk_frame(input string tg, input logic [20:0] b, input logic [20:0] s);
    int ed, es, ee;
    logic [20:0] a;
    ed = 0; es = 0; ee = 0;
    chk({tg, "_count"}, 32'(pop_q.size()), 32'd64);
    for (int j = 0; j < 64 && j < pop_q.size(); j++) begin
      a = b + ((j / H) == 1 ? s : 21'd0) + 21'(j % H);
      if (pop_q[j][31:0] !== tag(a)) ed++;
      if (pop_q[j][33] !== (j == 0)) es++;
      if (pop_q[j][32] !== ((j % H) == H - 1)) ee++;
    end
    chk({tg, "_data_errs"}, 32'(ed), 0);
    chk({tg, "_sof_errs"}, 32'(es), 0);
    chk({tg, "_eol_errs"}, 32'(ee), 0);
  endtask

  task automatic clear_logs();
    cmd_q.delete();
    pop_q.delete();
    fd_at = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge psramclk);
    start = 1'b0;
  endtask

  initial begin
    int   err;
    logic [20:0] a0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; buf_sel = 1'b0; force_rv = 1'b0;
    base0 = 21'h100; base1 = 21'h8000; stride = 21'd64;
    cmd_rdy = 1'b1; pix_rdy = 1'b1;
    clear_logs();
    repeat (3) @(negedge psramclk);

    // Reset state
    chk("rst_run", run, 0);
    chk("rst_cmd_en", bus.psram_cmd_en, 0);
    chk("rst_addr", bus.psram_addr, 0);
    chk("rst_pix_valid", bus.pix_valid, 0);
    chk("rst_pix_data", bus.pix_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_spurious", spurious, 0);
    chk("rst_cmd", bus.psram_cmd, 0);
    rst_n = 1'b1;
    @(negedge psramclk);

    // Stop while idle is ignored; start+stop together does not start.
    stop = 1'b1;
    @(negedge psramclk);
    start = 1'b1;
    @(negedge psramclk);
    start = 1'b0; stop = 1'b0;
    @(negedge psramclk);
    chk("start_stop_same_cycle_run", run, 0);

    // Full frame, stop raised during the 4th burst.
    pulse_start();
    chk("t1_run", run, 1);
    for (int i = 0; i < 400 && cmd_q.size() < 4; i++) @(negedge psramclk);
    stop = 1'b1;
    for (int i = 0; i < 400 && run; i++) @(negedge psramclk);
    stop = 1'b0;
    chk("t1_run_dropped", run, 0);
    chk("t1_cmd_count", 32'(cmd_q.size()), 4);
    if (cmd_q.size() >= 4) begin
      chk("t1_cmd0", cmd_q[0], 21'h100);
      chk("t1_cmd1", cmd_q[1], 21'h110);
      chk("t1_cmd2", cmd_q[2], 21'h140);
      chk("t1_cmd3", cmd_q[3], 21'h150);
    end
    chk("t1_frame_done_after_burst", 32'(fd_at), 4);
    chk_frame("t1", 21'h100, 21'd64);
    chk("t1_pix_valid_empty", bus.pix_valid, 0);
    chk("t1_cur_buf", cur_buf, 0);

    // Backpressure: FIFO of 32 holds exactly two bursts.
    clear_logs();
    pix_rdy = 1'b0;
    pulse_start();
    repeat (100) @(negedge psramclk);
    chk("t2_cmds_blocked", 32'(cmd_q.size()), 2);
    chk("t2_cmd_en_low", bus.psram_cmd_en, 0);
    chk("t2_run", run, 1);
    chk("t2_pix_valid", bus.pix_valid, 1);
    pix_rdy = 1'b1;
    for (int i = 0; i < 400 && cmd_q.size() < 4; i++) @(negedge psramclk);
    stop = 1'b1;
    for (int i = 0; i < 400 && run; i++) @(negedge psramclk);
    stop = 1'b0;
    chk("t2_run_dropped", run, 0);
    chk("t2_cmd_count", 32'(cmd_q.size()), 4);
    chk_frame("t2", 21'h100, 21'd64);

    // Command held off 10 cycles; also exercises 21-bit address wrap.
    clear_logs();
    base0 = 21'h1F_FFF0;
    cmd_rdy = 1'b0;
    pulse_start();
    for (int i = 0; i < 20 && !bus.psram_cmd_en; i++) @(negedge psramclk);
    chk("t3_cmd_en_up", bus.psram_cmd_en, 1);
    chk("t3_addr", bus.psram_addr, 21'h1F_FFF0);
    a0 = bus.psram_addr;
    err = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge psramclk);
      if (bus.psram_cmd_en !== 1'b1 || bus.psram_addr !== a0) err++;
    end
    chk("t3_stable_errs", 32'(err), 0);
    cmd_rdy = 1'b1;
    @(negedge psramclk);
    cmd_rdy = 1'b0;
    chk("t3_single_accept", 32'(cmd_q.size()), 1);
    chk("t3_cmd_en_dropped", bus.psram_cmd_en, 0);
    cmd_rdy = 1'b1;
    for (int i = 0; i < 400 && cmd_q.size() < 3; i++) @(negedge psramclk);
    stop = 1'b1;
    for (int i = 0; i < 400 && run; i++) @(negedge psramclk);
    stop = 1'b0;
    chk("t3_run_dropped", run, 0);
    if (cmd_q.size() >= 3) begin
      chk("t3_wrap_cmd1", cmd_q[1], 21'h00_0000);
      chk("t3_wrap_cmd2", cmd_q[2], 21'h00_0030);
    end else chk("t3_cmd_count", 32'(cmd_q.size()), 3);
    base0 = 21'h100;

`ifdef FETCH_DBUF_EN
    // Buffer switch takes effect at the next frame boundary.
    clear_logs();
    buf_sel = 1'b0;
    pulse_start();
    for (int i = 0; i < 400 && cmd_q.size() < 1; i++) @(negedge psramclk);
    buf_sel = 1'b1;
    for (int i = 0; i < 400 && cmd_q.size() < 2; i++) @(negedge psramclk);
    chk("t4_cur_buf_mid", cur_buf, 0);
    for (int i = 0; i < 800 && cmd_q.size() < 5; i++) @(negedge psramclk);
    stop = 1'b1;
    for (int i = 0; i < 400 && run; i++) @(negedge psramclk);
    stop = 1'b0;
    chk("t4_run_dropped", run, 0);
    if (cmd_q.size() >= 5) begin
      chk("t4_cmd3", cmd_q[3], 21'h150);
      chk("t4_cmd4", cmd_q[4], 21'h8000);
    end else chk("t4_cmd_count", 32'(cmd_q.size()), 5);
    chk("t4_cur_buf", cur_buf, 1);
    buf_sel = 1'b0;
`endif

    // Reset mid-burst, then late beats.
    clear_logs();
    chk("t5_spurious_before", spurious, 0);
    pulse_start();
    for (int i = 0; i < 100 && pop_q.size() < 4; i++) @(negedge psramclk);
    chk("t5_in_burst", 32'(pop_q.size()), 4);
    rst_n = 1'b0;
    @(negedge psramclk);
    chk("t5_rst_cmd_en", bus.psram_cmd_en, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      force_rv = 1'b1;
      @(negedge psramclk);
      force_rv = 1'b0;
      @(negedge psramclk);
    end
    chk("t5_spurious", spurious, 1);
    chk("t5_run", run, 0);
    chk("t5_pix_valid", bus.pix_valid, 0);
    chk("t5_pix_data", bus.pix_data, 0);
    chk("t5_cmd_en", bus.psram_cmd_en, 0);
    chk("t5_frame_done", frame_done, 0);
    chk("t5_cur_buf", cur_buf, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
